// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared types and constants for the multdiv sequencing controller
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    localparam int DEFAULT_MAX_CYCLES = 40;

endpackage

// File: rtl/multdiv_ctrl_if.sv
// multdiv_ctrl_if: issue, multdiv-unit and writeback signals of the controller
interface multdiv_ctrl_if #(
    parameter int TAG_W = 5
);
    logic             issue_valid;
    logic             issue_op;
    logic [31:0]      issue_a;
    logic [31:0]      issue_b;
    logic [TAG_W-1:0] issue_rd;
    logic             stall;
    logic [31:0]      md_a;
    logic [31:0]      md_b;
    logic             md_ctrl_mult;
    logic             md_ctrl_div;
    logic [31:0]      md_result;
    logic             md_exception;
    logic             md_rdy;
    logic             wb_valid;
    logic [TAG_W-1:0] wb_rd;
    logic [31:0]      wb_data;
    logic             wb_exception;

    // Execute stage plus multdiv unit side
    modport master (
        output issue_valid, issue_op, issue_a, issue_b, issue_rd,
        output md_result, md_exception, md_rdy,
        input  stall, md_a, md_b, md_ctrl_mult, md_ctrl_div,
        input  wb_valid, wb_rd, wb_data, wb_exception
    );

    // Controller side
    modport slave (
        input  issue_valid, issue_op, issue_a, issue_b, issue_rd,
        input  md_result, md_exception, md_rdy,
        output stall, md_a, md_b, md_ctrl_mult, md_ctrl_div,
        output wb_valid, wb_rd, wb_data, wb_exception
    );

endinterface

// File: rtl/md_watchdog.sv
// md_watchdog: 8-bit clear/enable cycle counter flagging the last allowed busy cycle
module md_watchdog
    import multdiv_pkg::*;
#(
    parameter int MAX_CYCLES = DEFAULT_MAX_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [7:0] count;

    // Count busy cycles; clear wins over enable
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en)
            count <= count + 8'd1;
    end

    assign tc = count == 8'(MAX_CYCLES - 1);

endmodule

// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: issues one mult/div to the multdiv unit, stalls until done or timeout, then writes back
module multdiv_ctrl
    import multdiv_pkg::*;
#(
    parameter int TAG_W      = 5,
    parameter int MAX_CYCLES = DEFAULT_MAX_CYCLES
) (
    input logic           clock,
    input logic           reset,
    multdiv_ctrl_if.slave bus
);

    state_t           state;
    state_t           next_state;
    logic             accept;
    logic             finish;
    logic             cnt_clr;
    logic             cnt_en;
    logic             tc;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic [TAG_W-1:0] rd_q;
    logic             mult_q;
    logic             div_q;
    logic             wb_valid_q;
    logic [TAG_W-1:0] wb_rd_q;
    logic [31:0]      wb_data_q;
    logic             wb_exc_q;

    md_watchdog #(.MAX_CYCLES(MAX_CYCLES)) u_watchdog (
        .clock (clock),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .tc    (tc)
    );

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Next state: md_rdy is only looked at in BUSY, so stale ready is ignored
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = bus.issue_valid ? START : IDLE;
            START:   next_state = BUSY;
            BUSY:    next_state = (bus.md_rdy || tc) ? DONE : BUSY;
            default: next_state = IDLE;
        endcase
    end

    // Control decode: acceptance, completion and watchdog control
    always_comb begin
        accept  = state == IDLE && bus.issue_valid;
        finish  = state == BUSY && (bus.md_rdy || tc);
        cnt_clr = state == START;
        cnt_en  = state == BUSY;
    end

    assign bus.stall = accept || state == START || state == BUSY;

    // Operand/tag latch on acceptance; held stable until the next issue
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_q  <= '0;
            b_q  <= '0;
            rd_q <= '0;
        end else if (accept) begin
            a_q  <= bus.issue_a;
            b_q  <= bus.issue_b;
            rd_q <= bus.issue_rd;
        end
    end

    // Start pulses: registered from the accepted op so they appear exactly in START
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mult_q <= 1'b0;
            div_q  <= 1'b0;
        end else begin
            mult_q <= accept && bus.issue_op == OP_MULT;
            div_q  <= accept && bus.issue_op == OP_DIV;
        end
    end

    // Writeback capture; ready beats timeout, and the data/tag hold until the next capture
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            wb_exc_q   <= 1'b0;
        end else begin
            wb_valid_q <= finish;
            if (finish) begin
                wb_rd_q   <= rd_q;
                wb_data_q <= bus.md_rdy ? bus.md_result : '0;
                wb_exc_q  <= bus.md_rdy ? bus.md_exception : 1'b1;
            end
        end
    end

    assign bus.md_a         = a_q;
    assign bus.md_b         = b_q;
    assign bus.md_ctrl_mult = mult_q;
    assign bus.md_ctrl_div  = div_q;
    assign bus.wb_valid     = wb_valid_q;
    assign bus.wb_rd        = wb_rd_q;
    assign bus.wb_data      = wb_data_q;
    assign bus.wb_exception = wb_exc_q;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// tb_multdiv_ctrl: randomized and directed checks of multdiv_ctrl against a cycle-timeline model
module tb_multdiv_ctrl;

    localparam int MAXC = 40;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    multdiv_ctrl_if #(.TAG_W(5)) bus ();

    multdiv_ctrl #(.TAG_W(5), .MAX_CYCLES(MAXC)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int          total = 0;
    int          bad   = 0;
    logic [31:0] last_data;
    logic [4:0]  last_rd;
    logic        last_exc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_noise();
        bus.issue_op = 1'($urandom());
        bus.issue_a  = $urandom();
        bus.issue_b  = $urandom();
        bus.issue_rd = 5'($urandom());
    endtask

    // One operation; k = BUSY cycle in which md_rdy arrives (0 or >MAXC means never -> timeout)
    task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int k, input bit stale);
        bit          hit;
        int          fin;
        logic [31:0] res;
        logic        exc;
        hit = k >= 1 && k <= MAXC;
        fin = hit ? k + 2 : MAXC + 2;
        res = !hit ? 32'h0 : (op ? (b == 0 ? 32'hDEAD_BEEF : a / b) : a * b);
        exc = hit ? (op && b == 0) : 1'b1;
        for (int n = 0; n <= fin; n++) begin
            @(negedge clock);
            drive_noise();
            bus.issue_valid = n == 0 ? 1'b1 : 1'($urandom());
            if (n == 0) begin
                bus.issue_op = op;
                bus.issue_a  = a;
                bus.issue_b  = b;
                bus.issue_rd = rd;
            end
            bus.md_rdy       = hit && (n == k + 1 || (stale && n <= k + 1));
            bus.md_result    = (hit && n == k + 1) ? res : $urandom();
            bus.md_exception = (hit && n == k + 1) ? exc : 1'($urandom());
            #1;
            check("stall", bus.stall, n < fin);
            check("ctrl_mult", bus.md_ctrl_mult, n == 1 && !op);
            check("ctrl_div", bus.md_ctrl_div, n == 1 && op);
            check("wb_valid", bus.wb_valid, n == fin);
            if (n >= 1) begin
                check("md_a", bus.md_a, a);
                check("md_b", bus.md_b, b);
            end
            if (n < fin) begin
                check("wb_data_hold", bus.wb_data, last_data);
                check("wb_rd_hold", bus.wb_rd, last_rd);
                check("wb_exc_hold", bus.wb_exception, last_exc);
            end else begin
                check("wb_data", bus.wb_data, res);
                check("wb_rd", bus.wb_rd, rd);
                check("wb_exc", bus.wb_exception, exc);
                last_data = res;
                last_rd   = rd;
                last_exc  = exc;
            end
        end
    endtask

    task automatic idle_cycles(input int cnt);
        for (int n = 0; n < cnt; n++) begin
            @(negedge clock);
            drive_noise();
            bus.issue_valid = 1'b0;
            bus.md_rdy      = 1'($urandom());
            #1;
            check("idle_stall", bus.stall, 0);
            check("idle_wb_valid", bus.wb_valid, 0);
            check("idle_ctrl", {bus.md_ctrl_mult, bus.md_ctrl_div}, 0);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_mult", bus.md_ctrl_mult, 0);
        check("rst_div", bus.md_ctrl_div, 0);
        check("rst_wb_valid", bus.wb_valid, 0);
        check("rst_wb_exc", bus.wb_exception, 0);
        check("rst_wb_data", bus.wb_data, 0);
        check("rst_wb_rd", bus.wb_rd, 0);
        check("rst_md_a", bus.md_a, 0);
        check("rst_md_b", bus.md_b, 0);
    endtask

    // Issue a mult, then assert reset asynchronously in BUSY cycle 10
    task automatic reset_mid();
        for (int n = 0; n <= 11; n++) begin
            @(negedge clock);
            drive_noise();
            bus.issue_valid = n == 0;
            bus.md_rdy      = 1'b0;
            if (n == 0) begin
                bus.issue_op = 1'b0;
                bus.issue_a  = 32'd11;
                bus.issue_b  = 32'd13;
                bus.issue_rd = 5'd17;
            end
        end
        #2 reset = 1'b1;
        #1;
        check_reset_outputs();
        check("rst_stall", bus.stall, 0);
        last_data = '0;
        last_rd   = '0;
        last_exc  = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        idle_cycles(5);
    endtask

    initial begin
        reset            = 1'b1;
        bus.issue_valid  = 1'b0;
        bus.md_rdy       = 1'b0;
        bus.md_result    = '0;
        bus.md_exception = 1'b0;
        drive_noise();
        last_data = '0;
        last_rd   = '0;
        last_exc  = 1'b0;
        #2;
        check_reset_outputs();
        check("rst_stall_lo", bus.stall, 0);
        bus.issue_valid = 1'b1;
        #1;
        check("rst_stall_hi", bus.stall, 1);
        bus.issue_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        idle_cycles(2);
        run_op(1'b0, 32'd7, 32'd6, 5'd5, 33, 1'b0);
        run_op(1'b1, 32'd100, 32'd0, 5'd9, 5, 1'b0);
        run_op(1'b0, $urandom(), $urandom(), 5'd3, 0, 1'b0);
        idle_cycles(1);
        run_op(1'b1, 32'd99, 32'd4, 5'd21, 1, 1'b1);
        reset_mid();
        run_op(1'b0, 32'd7, 32'd6, 5'd5, 33, 1'b0);
        run_op(1'b0, 32'd12, 32'd12, 5'd1, 3, 1'b0);
        run_op(1'b1, 32'd81, 32'd9, 5'd2, 3, 1'b0);
        for (int i = 0; i < 25; i++) begin
            int k;
            k = $urandom_range(1, 45);
            run_op(1'($urandom()), $urandom(), ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom(),
                   5'($urandom()), k, k == 1 && $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 2) == 0)
                idle_cycles($urandom_range(1, 3));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multdiv_ctrl.md
# multdiv_ctrl

Sequencing controller between the execute stage and the `multdiv` unit. It accepts one multiply or divide request at a time, latches the operands and destination tag, and issues a single-cycle `ctrl_MULT`/`ctrl_DIV` start pulse. It stalls the pipeline until `data_resultRDY` arrives or a watchdog expires, then presents a one-cycle writeback.

## Interface

Parameters:

- `TAG_W`, 5: destination register tag width.
- `MAX_CYCLES`, 40: watchdog limit, counted in BUSY cycles; range 2..255.

Ports:

- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `issue_valid`  in  1  execute stage presents a mult/div.
- `issue_op`  in  1  0 = mult, 1 = div; meaningful only with `issue_valid`.
- `issue_a`, `issue_b`  in  32  operands.
- `issue_rd`  in  TAG_W  destination register.
- `stall`  out  1  pipeline hold request.
- `md_a`, `md_b`  out  32  to multdiv `data_operandA`/`data_operandB`; stable from START to DONE inclusive.
- `md_ctrl_mult`, `md_ctrl_div`  out  1  one-cycle start pulses.
- `md_result`  in  32  multdiv `data_result`.
- `md_exception`  in  1  multdiv `data_exception`.
- `md_rdy`  in  1  multdiv `data_resultRDY`.
- `wb_valid`  out  1  one-cycle writeback strobe.
- `wb_rd`  out  TAG_W  writeback tag.
- `wb_data`  out  32  result.
- `wb_exception`  out  1  multdiv exception OR watchdog timeout.

## Operation

- FSM states and transitions:
  - IDLE: when `issue_valid`=1, latch `issue_a/b/op/rd` and go to START.
  - START: assert exactly one of `md_ctrl_mult`/`md_ctrl_div` per the latched op, clear the counter, go to BUSY.
  - BUSY: the counter increments each cycle.
    - `md_rdy`=1: capture `md_result` and `md_exception`, go to DONE.
    - Otherwise, counter reaches MAX_CYCLES-1: capture `wb_data`=0 and `wb_exception`=1, go to DONE.
    - `md_rdy` has priority over timeout in the same cycle.
  - DONE: `wb_valid`=1, go to IDLE.
- `stall` = (state==IDLE && `issue_valid`) || state==START || state==BUSY. `stall` is low in DONE, so the pipeline advances on the writeback edge.
- `md_rdy` is sampled only in BUSY. A stale high `md_rdy` during IDLE or START, left over from the previous operation, is ignored.
- `issue_*` inputs are ignored outside IDLE.
- `md_ctrl_*`, `wb_*` and `md_a/b` are registered outputs. `stall` is combinational.
- `wb_rd`/`wb_data`/`wb_exception` hold their values after DONE until the next capture. Consumers qualify them with `wb_valid`.
- Divide-by-zero is not detected here; it arrives via `md_exception` and passes through to `wb_exception`.

## Timing

- Reset (async assert): state IDLE; `md_ctrl_*`, `wb_valid`, `wb_exception` = 0; `md_a`, `md_b`, `wb_data`, `wb_rd` = 0; counter 0. `stall` follows `issue_valid`.
- Reset mid-operation aborts the operation: no `wb_valid` is produced and no start pulse repeats.
- Latency, with issue in cycle 0 and `md_rdy` first high in BUSY cycle k (k≥1):
  - START in cycle 1.
  - BUSY in cycles 2..k+1.
  - DONE / `wb_valid` in cycle k+2.
- Timeout: `wb_valid` in cycle MAX_CYCLES+2 after issue.
- Back-to-back: a new issue is accepted in the IDLE cycle directly after DONE. Throughput is therefore at most one operation per k+3 cycles.
- `md_ctrl_mult`/`md_ctrl_div` are never high together and never high for more than one cycle per accepted issue.

## Structure

- Shared package `multdiv_pkg`:
  - State enum IDLE/START/BUSY/DONE.
  - Op constants `OP_MULT`=0, `OP_DIV`=1.
  - Default `MAX_CYCLES`.
- One sub-module: `md_watchdog`, an 8-bit clear/enable counter with a terminal-count output, parameterised by MAX_CYCLES.
- The FSM, operand/tag registers and writeback registers live in `multdiv_ctrl`.

## Test plan

- Mult 7×6, rd=5, `md_rdy` high in BUSY cycle 33 -> `md_ctrl_mult` one pulse at cycle 1; `wb_valid` at cycle 35 with `wb_data`=42, `wb_rd`=5, `wb_exception`=0; `stall` high cycles 0–34.
- Div 100/0, rd=9, model asserts `md_exception` with `md_rdy` -> `md_ctrl_div` pulse only; `wb_exception`=1, `wb_rd`=9.
- MAX_CYCLES=40, `md_rdy` held low -> `wb_valid` at cycle 42 with `wb_data`=0 and `wb_exception`=1; FSM returns to IDLE.
- `md_rdy` held high through IDLE and START (stale) -> not accepted; the FSM leaves BUSY only after `md_rdy`=1 in BUSY cycle 1, giving `wb_valid` at cycle 3.
- Reset asserted in BUSY cycle 10 -> all outputs 0 asynchronously; no `wb_valid`; a new issue after reset behaves as the first test.
- Two back-to-back issues (mult then div, k=3) -> two start pulses, two `wb_valid` strobes 6 cycles apart, correct tags, no overlap.
